// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide controller.
package multdiv_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_TAG_W  = 5;
    localparam int unsigned ITERATIONS = DEF_WIDTH;
    localparam logic [DEF_WIDTH-1:0] MIN_INT = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration over {acc_hi, acc_lo}: shift-add for multiply,
// restoring trial-subtract for divide. Operates on magnitudes only.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             mode_div_i,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_hi_c_o,
    output logic [WIDTH-1:0] acc_lo_c_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             unused_diff;

    assign unused_diff = diff[WIDTH];

    always_comb begin
        sum        = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh     = {acc_hi_i, acc_lo_i[WIDTH-1]};
        diff       = {1'b0, rem_sh} - {2'b00, opnd_i};
        acc_hi_c_o = acc_hi_i;
        acc_lo_c_o = acc_lo_i;
        if (mode_div_i) begin
            // Remainder stays below the divisor, so a non-negative trial fits WIDTH bits.
            if (!diff[WIDTH+1]) begin
                acc_hi_c_o = diff[WIDTH-1:0];
                acc_lo_c_o = {acc_lo_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_c_o = rem_sh[WIDTH-1:0];
                acc_lo_c_o = {acc_lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_c_o = sum[WIDTH:1];
            acc_lo_c_o = {sum[0], acc_lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the multi-cycle signed multiply/divide unit:
// stalls the front end while iterating and pulses the result for one cycle.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             cancel,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] dest_reg,
    output logic             stall,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             result_valid,
    output logic [TAG_W-1:0] result_reg
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] NEG_ONE  = {WIDTH{1'b1}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               valid_q, valid_d;
    logic [TAG_W-1:0]   rreg_q, rreg_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic               mult_exc;
    logic               div_by_zero, div_ovf;

    multdiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_div_i (state_q == DIV),
        .acc_hi_i   (hi_q),
        .acc_lo_i   (lo_q),
        .opnd_i     (opnd_q),
        .acc_hi_c_o (step_hi),
        .acc_lo_c_o (step_lo)
    );

    // Operand magnitudes and final sign fix-up of the last iteration's output.
    always_comb begin
        abs_a       = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b       = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        div_by_zero = (data_operandB == '0);
        div_ovf     = (data_operandA == MIN_VAL) && (data_operandB == NEG_ONE);
        prod        = {step_hi, step_lo};
        prod_s      = neg_q ? -prod : prod;
        mult_exc    = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
        quot_s      = neg_q ? -step_lo : step_lo;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            valid_q  <= 1'b0;
            rreg_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            valid_q  <= valid_d;
            rreg_q   <= rreg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        tag_d    = tag_q;
        result_d = result_q;
        exc_d    = exc_q;
        valid_d  = 1'b0;
        rreg_d   = rreg_q;

        if (cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl_mult) begin
                        state_d = MULT;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = abs_b;
                        opnd_d  = abs_a;
                        neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        tag_d   = dest_reg;
                    end else if (ctrl_div) begin
                        // Zero divisor and MIN/-1 finish without iterating.
                        if (div_by_zero || div_ovf) begin
                            state_d  = DONE;
                            valid_d  = 1'b1;
                            result_d = div_ovf ? MIN_VAL : '0;
                            exc_d    = 1'b1;
                            rreg_d   = dest_reg;
                        end else begin
                            state_d = DIV;
                            cnt_d   = '0;
                            hi_d    = '0;
                            lo_d    = abs_a;
                            opnd_d  = abs_b;
                            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                            tag_d   = dest_reg;
                        end
                    end
                end
                MULT, DIV: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        rreg_d  = tag_q;
                        if (state_q == MULT) begin
                            result_d = prod_s[WIDTH-1:0];
                            exc_d    = mult_exc;
                        end else begin
                            result_d = quot_s;
                            exc_d    = 1'b0;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Stall is combinational so the pipeline freezes in the request cycle itself.
    assign stall = !reset && !cancel &&
                   (((state_q == IDLE) && (ctrl_mult || ctrl_div)) ||
                    (state_q == MULT) || (state_q == DIV));

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign result_valid   = valid_q;
    assign result_reg     = rreg_q;

endmodule
